// File: rtl/mem_master.sv
// Initiator for the start/rwn/ready memory handshake: single-word load/store and 2-word read burst.
// Optional BUSY watchdog enabled by defining MEM_MASTER_TIMEOUT_EN.
module mem_master #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_rwn,
  input  logic                req_burst,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [2*DATA_W-1:0] resp_rdata,
  output logic                resp_err,
  output logic                mem_start,
  output logic                mem_rwn,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_data_in,
  input  logic [DATA_W-1:0]   mem_data_out,
  input  logic                mem_ready
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                rwn_d;
  logic [DATA_W-1:0]   wdata_d;
  logic                burst_q, burst_d;
  logic                idx_q, idx_d;
  logic [DATA_W-1:0]   word0_q, word0_d;
  logic [2*DATA_W-1:0] rdata_d;
  logic                err_d;
  logic                timeout_c;

  // A memory still finishing a pre-reset access must block new requests.
  assign req_ready = (state_q == IDLE) & mem_ready;

`ifdef MEM_MASTER_TIMEOUT_EN
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;

  // Consecutive BUSY cycles without mem_ready for the current word.
  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (state_q == ISSUE) begin
      busy_cnt_d = '0;
    end else if ((state_q == BUSY) && !mem_ready) begin
      busy_cnt_d = busy_cnt_q + CNT_W'(1);
    end
  end

  assign timeout_c = (state_q == BUSY) && !mem_ready &&
                     (busy_cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_cnt_q <= '0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
    end
  end
`else
  logic [CNT_W-1:0] timeout_unused;
  assign timeout_unused = CNT_W'(TIMEOUT);
  assign timeout_c      = 1'b0;
`endif

  // Next-state and next-register values.
  always_comb begin
    state_d = state_q;
    addr_d  = mem_address;
    rwn_d   = mem_rwn;
    wdata_d = mem_data_in;
    burst_d = burst_q;
    idx_d   = idx_q;
    word0_d = word0_q;
    rdata_d = resp_rdata;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_d  = req_addr;
          rwn_d   = req_rwn;
          wdata_d = req_wdata;
          burst_d = req_burst & req_rwn;
          idx_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = BUSY;
      end
      BUSY: begin
        if (mem_ready) begin
          if (burst_q && !idx_q) begin
            word0_d = mem_data_out;
            idx_d   = 1'b1;
            addr_d  = ADDR_W'(mem_address + ADDR_W'(1));
            state_d = ISSUE;
          end else begin
            if (mem_rwn) begin
              rdata_d = burst_q ? {word0_q, mem_data_out}
                                : {DATA_W'(0), mem_data_out};
            end
            state_d = RESP;
          end
        end else if (timeout_c) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction silently.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_address <= '0;
      mem_rwn     <= 1'b1;
      mem_data_in <= '0;
      burst_q     <= 1'b0;
      idx_q       <= 1'b0;
      word0_q     <= '0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      resp_valid  <= 1'b0;
      mem_start   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_address <= addr_d;
      mem_rwn     <= rwn_d;
      mem_data_in <= wdata_d;
      burst_q     <= burst_d;
      idx_q       <= idx_d;
      word0_q     <= word0_d;
      resp_rdata  <= rdata_d;
      resp_err    <= err_d;
      resp_valid  <= (state_d == RESP);
      mem_start   <= (state_d == ISSUE);
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Scoreboard bench for mem_master with a behavioural 256x16 memory (latency addr[1:0]+1).
module tb_mem_master;

  localparam int unsigned TB_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rwn = 1'b1;
  logic        req_burst = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_start;
  logic        mem_rwn;
  logic [7:0]  mem_address;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic        mem_ready;

  mem_master #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rwn(req_rwn),
    .req_burst(req_burst), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_start(mem_start), .mem_rwn(mem_rwn), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model, never reset, so it can stay busy across a master reset.
  logic [15:0] mem [256];
  logic [7:0]  m_addr = '0;
  logic        m_rwn = 1'b1;
  logic [15:0] m_wdata = '0;
  logic [2:0]  m_cnt = '0;
  logic        m_ready = 1'b1;
  logic [15:0] m_dout = '0;
  logic        stall = 1'b0;
  assign mem_ready    = m_ready;
  assign mem_data_out = m_dout;

  always @(posedge clk) begin
    if (mem_start) begin
      m_addr  <= mem_address;
      m_rwn   <= mem_rwn;
      m_wdata <= mem_data_in;
      m_cnt   <= {1'b0, mem_address[1:0]} + 3'd1;
      m_ready <= 1'b0;
    end else if (m_cnt != 3'd0 && !stall) begin
      m_cnt <= m_cnt - 3'd1;
      if (m_cnt == 3'd1) begin
        m_ready <= 1'b1;
        if (m_rwn) m_dout <= mem[m_addr];
        else       mem[m_addr] <= m_wdata;
      end
    end
  end

  typedef struct { logic [31:0] rdata; logic err; int cyc; } resp_t;
  typedef struct { logic [7:0] addr; logic rwn; logic [15:0] wdata; } start_t;
  resp_t  resp_q[$];
  start_t start_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;
  bit prev_resp = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT presents a strobe.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_resp) chk("ready_after_resp", 64'(req_ready), 64'(mem_ready));
      if (resp_valid) begin
        chk("resp_ready_overlap", 64'(req_ready), 64'd0);
        if (resp_q.size() == 0) begin
          chk("unexpected_resp", 64'd1, 64'd0);
        end else begin
          resp_t e;
          e = resp_q.pop_front();
          chk("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
          chk("resp_err", 64'(resp_err), 64'(e.err));
          chk("resp_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (mem_start) begin
        if (start_q.size() == 0) begin
          chk("unexpected_start", 64'd1, 64'd0);
        end else begin
          start_t s;
          s = start_q.pop_front();
          chk("start_addr", 64'(mem_address), 64'(s.addr));
          chk("start_rwn", 64'(mem_rwn), 64'(s.rwn));
          if (!s.rwn) chk("start_wdata", 64'(mem_data_in), 64'(s.wdata));
        end
      end
      prev_resp <= resp_valid;
    end
  end

  // Drive one request; expectations are pushed just before the accept edge.
  task automatic issue(input logic rwn, input logic burst, input logic [7:0] addr,
                       input logic [15:0] wdata, input bit exp_resp,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat);
    int g;
    start_t s;
    resp_t r;
    @(negedge clk);
    req_valid = 1'b1; req_rwn = rwn; req_burst = burst;
    req_addr = addr; req_wdata = wdata;
    g = 0;
    while (!req_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("accept_wait", 64'(req_ready), 64'd1);
    s.addr = addr; s.rwn = rwn; s.wdata = wdata;
    start_q.push_back(s);
    if (rwn && burst) begin
      s.addr = addr + 8'd1;
      start_q.push_back(s);
    end
    if (exp_resp) begin
      r.rdata = exp_rdata; r.err = exp_err; r.cyc = cyc + 1 + lat;
      resp_q.push_back(r);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_rwn = 1'b0; req_burst = 1'b1; req_addr = 8'hAA; req_wdata = 16'hDEAD;
  endtask

  task automatic drain();
    int g = 0;
    while ((resp_q.size() != 0 || start_q.size() != 0) && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain", 64'(resp_q.size() + start_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_mem_start", 64'(mem_start), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    chk("rst_mem_address", 64'(mem_address), 64'd0);
    chk("rst_mem_data_in", 64'(mem_data_in), 64'd0);
    chk("rst_mem_rwn", 64'(mem_rwn), 64'd1);
  endtask

  initial begin
    int g;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[249] = 16'h0005;
    mem[0]   = 16'h6140;
    mem[1]   = 16'h0002;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    mon_en = 1'b1;

    // Single read, latency 1+3
    issue(1'b1, 1'b0, 8'd249, 16'h0, 1'b1, 32'h0000_0005, 1'b0, 4);
    drain();
    // Write holds previous rdata, then readback; latency 3+3
    issue(1'b0, 1'b0, 8'd3, 16'hBEEF, 1'b1, 32'h0000_0005, 1'b0, 6);
    drain();
    issue(1'b1, 1'b0, 8'd3, 16'h0, 1'b1, 32'h0000_BEEF, 1'b0, 6);
    drain();
    // Bursts: latency 4 + k0 + k1
    issue(1'b1, 1'b1, 8'd0, 16'h0, 1'b1, 32'h6140_0002, 1'b0, 7);
    drain();
    issue(1'b1, 1'b1, 8'd255, 16'h0, 1'b1, 32'h0000_6140, 1'b0, 9);
    drain();
    // Burst flag on a write is a single write
    issue(1'b0, 1'b1, 8'd2, 16'h1234, 1'b1, 32'h0000_6140, 1'b0, 5);
    drain();
    issue(1'b1, 1'b0, 8'd2, 16'h0, 1'b1, 32'h0000_1234, 1'b0, 5);
    drain();

    // Reset during BUSY of a read at addr 3: no response, ready blocked by memory
    issue(1'b1, 1'b0, 8'd3, 16'h0, 1'b0, 32'h0, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_reset_outputs();
    chk("rst_mem_busy", 64'(mem_ready), 64'd0);
    g = 0;
    while (!mem_ready && g < 20) begin
      chk("rst_ready_blocked", 64'(req_ready), 64'd0);
      @(negedge clk);
      g++;
    end
    chk("rst_ready_released", 64'(req_ready), 64'd1);
    drain();
    issue(1'b1, 1'b0, 8'd249, 16'h0, 1'b1, 32'h0000_0005, 1'b0, 4);
    drain();

`ifdef MEM_MASTER_TIMEOUT_EN
    // Memory stalls: timeout response after TIMEOUT BUSY cycles, rdata unchanged
    stall = 1'b1;
    issue(1'b1, 1'b1, 8'd1, 16'h0, 1'b1, 32'h0000_0005, 1'b1, 1 + int'(TB_TIMEOUT));
    drain();
    stall = 1'b0;
    g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("timeout_recover", 64'(req_ready), 64'd1);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
